seq_shl: RTL

SEQ_SHL -- requirements
Module: seq_shl

---
 rtl/seq_shl_pkg.sv | 14 +
 rtl/seq_shl_step.sv | 14 +
 rtl/seq_shl.sv | 99 +++++++++
 3 files changed

// File: rtl/seq_shl_pkg.sv
// Shared types and default sizes for the sequential left shifter (seq_shl).
// Optional early termination is enabled with the SEQ_SHL_ZERO_SKIP_EN macro.
package seq_shl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_AMTWIDTH  = 3;

endpackage : seq_shl_pkg

// File: rtl/seq_shl_step.sv
// Combinational single-bit left shift of the accumulator, with a zero flag
// on the shifted value so the controller can stop early when it is enabled.
module seq_shl_step #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] acc_in,
    output logic [DATAWIDTH-1:0] acc_out,
    output logic                 acc_out_zero
);

    assign acc_out      = acc_in << 1;
    assign acc_out_zero = (acc_out == '0);

endmodule : seq_shl_step

// File: rtl/seq_shl.sv
// Sequential left shifter: accepts a/sh_amt in IDLE, shifts one bit per clock
// in SHIFT, and holds the result in DONE until out_ready. Define
// SEQ_SHL_ZERO_SKIP_EN to finish as soon as the accumulator becomes zero.
module seq_shl
    import seq_shl_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int AMTWIDTH  = DEF_AMTWIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [AMTWIDTH-1:0]  sh_amt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] d,
    output logic                 busy
);

`ifdef SEQ_SHL_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [DATAWIDTH-1:0]   acc_q, acc_d;
    logic [AMTWIDTH-1:0]    cnt_q, cnt_d;
    logic [DATAWIDTH-1:0]   acc_shl;
    logic                   acc_shl_zero;

    seq_shl_step #(
        .DATAWIDTH (DATAWIDTH)
    ) u_step (
        .acc_in       (acc_q),
        .acc_out      (acc_shl),
        .acc_out_zero (acc_shl_zero)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d = a;
                    cnt_d = sh_amt;
                    if (sh_amt == '0 || (ZERO_SKIP && a == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_shl;
                cnt_d = cnt_q - AMTWIDTH'(1);
                // cnt counts the shifts still owed, including this edge's.
                if (cnt_q == AMTWIDTH'(1) || (ZERO_SKIP && acc_shl_zero)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, regardless of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign d         = acc_q;

endmodule : seq_shl
